mac_rx_frame_fifo: RTL
======================

# mac_rx_frame_fifo

Store-and-forward receive buffer between the MAC receiver client interface (8-bit AXI-Stream, no `tready`, `tuser` = bad frame) and the `from_mac_*` input of the LegoFPGA system. It writes every incoming beat unconditionally and releases a frame downstream only after its last beat arrives clean. Frames flagged bad by the MAC, or frames that overflow the buffer, are discarded whole and counted. Downstream therefore sees only complete, good frames with proper `tready` backpressure.

## Interface
Parameters:
- `DEPTH`, 4096: data-RAM entries (bytes); power of two, ≥ 64.
- `CNT_W`, 32: width of the statistics counters.

Ports:
- `clk_125`  in  1  sole clock (MAC client clock).
- `clk_125_rstn`  in  1  reset; asynchronous assert, active-low.
- `s_tdata`  in  8  MAC rx byte.
- `s_tvalid`  in  1  beat valid; no ready is returned.
- `s_tlast`  in  1  last byte of frame.
- `s_tuser`  in  1  bad-frame flag; meaningful only with `s_tlast`.
- `m_tdata`  out  8  byte to system.
- `m_tvalid`  out  1  output valid.
- `m_tlast`  out  1  last byte of frame.
- `m_tready`  in  1  system ready.
- `frames_good`  out  `CNT_W`  frames committed.
- `frames_bad`  out  `CNT_W`  frames dropped because of `s_tuser`.
- `frames_ovf`  out  `CNT_W`  frames dropped because of overflow.

## Operation
- RAM entry is 9 bits: {tlast, data}. Pointers `wr_ptr`, `commit_ptr` and `rd_ptr` are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. The buffer is full when `wr_ptr - rd_ptr == DEPTH`.
- Input FSM has two states, `S_ACCEPT` and `S_DROP`. Reset state is `S_ACCEPT`.
- In `S_ACCEPT`, a valid beat that arrives while the buffer is not full is written at `wr_ptr`, and `wr_ptr` increments.
  - If the beat has `s_tlast=1` and `s_tuser=0`: `commit_ptr ← wr_ptr+1`, and `frames_good` increments.
  - If the beat has `s_tlast=1` and `s_tuser=1`: `wr_ptr ← commit_ptr` (rewind), and `frames_bad` increments.
- In `S_ACCEPT`, a valid beat that arrives while the buffer is full triggers an overflow:
  - `wr_ptr ← commit_ptr`.
  - If the beat also has `s_tlast`, `frames_ovf` increments and the FSM stays in `S_ACCEPT`.
  - Otherwise the FSM moves to `S_DROP`.
- In `S_DROP`, all beats are discarded. On the beat with `s_tlast`, `frames_ovf` increments and the FSM returns to `S_ACCEPT`. `s_tuser` is ignored in this state.
- Output side reads only in the range `rd_ptr` to `commit_ptr`. Uncommitted data is never visible downstream.
- Counters saturate at all-ones; they do not wrap.
- Bytes are never reordered. A good frame is delivered byte-exact.

## Timing
- Reset values: `m_tvalid=0`, `m_tlast=0`, `m_tdata=0`, all counters 0, all pointers 0, FSM in `S_ACCEPT`.
- RAM has a 1-cycle registered read. Output uses a 2-entry prefetch/skid so it can stream 1 byte/cycle while `m_tready=1`.
- Commit latency: the last beat is written in cycle T, `commit_ptr` updates at T+1. If the output was empty, `m_tvalid` rises at T+2 with the first byte of the frame.
- AXIS rules on the output:
  - Once `m_tvalid` is high, `m_tdata`/`m_tlast` hold stable until `m_tready`.
  - `m_tvalid` never depends combinationally on `m_tready`.
- Simultaneous events:
  - Commit and read in the same cycle are both honoured.
  - A read that frees space in the same cycle a write arrives at full does not prevent the overflow. Full is evaluated on registered pointers.
- Rewind never moves `wr_ptr` behind `rd_ptr`, because `commit_ptr ≥ rd_ptr` always holds.
- Reset asserted mid-frame or mid-read discards all contents immediately. After release, input beats are treated as the start of a new frame, so a frame tail arriving then is stored as a fragment. The system tolerates this.
- Counters update one cycle after the triggering beat.

## Structure
- Shared package `legofpga_net_pkg` holds:
  - `rx_fsm_e` (`S_ACCEPT`, `S_DROP`).
  - The 9-bit RAM word typedef.
  - `DATA_W=8`.
- One sub-module, `mac_rx_frame_ram`: simple dual-port, 9×`DEPTH`, one write port, one registered read port. It infers BRAM.
- Pointer logic, FSM, output skid and counters live in the top module.

## Test plan
- Back-to-back good frames: three 64-byte frames with `m_tready=1` → 192 bytes out in order, `m_tlast` on bytes 64/128/192, `frames_good=3`, first `m_tvalid` 2 cycles after the first input `tlast`.
- Bad frame sandwiched: good 60-byte frame, then 100-byte frame with `tuser=1`, then good 70-byte frame → output is exactly 60+70 bytes, `frames_bad=1`, `frames_good=2`.
- Overflow: `DEPTH=64`, `m_tready=0`, 40-byte good frame then 30-byte frame → second frame dropped, `frames_ovf=1`. Raising `m_tready` yields only the 40-byte frame. A following 20-byte frame is then accepted.
- Backpressure: 1500-byte frame with `m_tready` toggling 1-0-1-1-0 → output data stable during stalls, all 1500 bytes intact.
- Single-byte frames and wrap: 200 one-byte good frames with `DEPTH=64` and `m_tready=1` → 200 bytes out, each with `m_tlast=1`, pointers wrap cleanly.
- Reset mid-operation: assert `clk_125_rstn=0` during byte 30 of a frame and while output is streaming → `m_tvalid` drops to 0 asynchronously, counters read 0, next full frame after release passes correctly.

Source files
------------

// File: rtl/legofpga_net_pkg.sv
// Shared types for the LegoFPGA network datapath.
// Holds the rx FSM encoding and the frame-buffer RAM word.
package legofpga_net_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    S_ACCEPT = 1'b0,
    S_DROP   = 1'b1
  } rx_fsm_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } ram_word_t;

endpackage

// File: rtl/mac_rx_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read.
// No reset on the array or read register so it maps onto block RAM.
module mac_rx_frame_ram
  import legofpga_net_pkg::*;
#(
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  ram_word_t       wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output ram_word_t       rdata_o
);

  ram_word_t mem_q [DEPTH];
  ram_word_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mac_rx_frame_fifo.sv
// Store-and-forward MAC rx buffer: frames are released only once
// their last beat arrives clean; bad or overflowing frames are dropped.
module mac_rx_frame_fifo
  import legofpga_net_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int CNT_W = 32
) (
  input  logic              clk_125,
  input  logic              clk_125_rstn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  input  logic              s_tuser,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [CNT_W-1:0]  frames_good,
  output logic [CNT_W-1:0]  frames_bad,
  output logic [CNT_W-1:0]  frames_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_GAP = PW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  rx_fsm_e st_q, st_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] cm_q, cm_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  ram_word_t s0_q, s0_d;
  ram_word_t s1_q, s1_d;
  logic [1:0] cnt_q, cnt_d;
  logic rv_q;
  logic we, re, full, pop, push;
  ram_word_t wdata, rdata, out_w;

  assign wdata = '{last: s_tlast, data: s_tdata};

  mac_rx_frame_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk_125),
    .we_i   (we),
    .waddr_i(wr_q[AW-1:0]),
    .wdata_i(wdata),
    .re_i   (re),
    .raddr_i(rd_q[AW-1:0]),
    .rdata_o(rdata)
  );

  // Counters saturate: increment only while not all-ones.
  always_comb begin
    st_d   = st_q;
    wr_d   = wr_q;
    cm_d   = cm_q;
    good_d = good_q;
    bad_d  = bad_q;
    ovf_d  = ovf_q;
    we     = 1'b0;
    full   = (wr_q - rd_q) == FULL_GAP;
    unique case (st_q)
      S_ACCEPT: begin
        if (s_tvalid && !full) begin
          we   = 1'b1;
          wr_d = wr_q + 1'b1;
          if (s_tlast && !s_tuser) begin
            cm_d   = wr_q + 1'b1;
            good_d = good_q + (&good_q ? '0 : CNT_ONE);
          end else if (s_tlast) begin
            wr_d  = cm_q;
            bad_d = bad_q + (&bad_q ? '0 : CNT_ONE);
          end
        end else if (s_tvalid) begin
          wr_d = cm_q;
          if (s_tlast) begin
            ovf_d = ovf_q + (&ovf_q ? '0 : CNT_ONE);
          end else begin
            st_d = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (s_tvalid && s_tlast) begin
          ovf_d = ovf_q + (&ovf_q ? '0 : CNT_ONE);
          st_d  = S_ACCEPT;
        end
      end
      default: st_d = S_ACCEPT;
    endcase
  end

  assign m_tvalid = rv_q | (cnt_q != 2'd0);

  // RAM read word bypasses the skid when it is empty, else parks in it.
  always_comb begin
    pop   = m_tvalid && m_tready;
    push  = rv_q && !(pop && (cnt_q == 2'd0));
    s0_d  = s0_q;
    s1_d  = s1_q;
    cnt_d = cnt_q;
    if (pop && (cnt_q != 2'd0)) begin
      s0_d  = s1_q;
      cnt_d = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) s0_d = rdata;
      else               s1_d = rdata;
      cnt_d = cnt_d + 2'd1;
    end
    re   = (rd_q != cm_q) && (cnt_d < 2'd2);
    rd_d = rd_q + {{AW{1'b0}}, re};
  end

  always_comb begin
    out_w = '0;
    if (cnt_q != 2'd0) out_w = s0_q;
    else if (rv_q)     out_w = rdata;
  end

  assign m_tdata     = out_w.data;
  assign m_tlast     = out_w.last;
  assign frames_good = good_q;
  assign frames_bad  = bad_q;
  assign frames_ovf  = ovf_q;

  always_ff @(posedge clk_125 or negedge clk_125_rstn) begin
    if (!clk_125_rstn) begin
      st_q   <= S_ACCEPT;
      wr_q   <= '0;
      cm_q   <= '0;
      rd_q   <= '0;
      good_q <= '0;
      bad_q  <= '0;
      ovf_q  <= '0;
      s0_q   <= '0;
      s1_q   <= '0;
      cnt_q  <= '0;
      rv_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      wr_q   <= wr_d;
      cm_q   <= cm_d;
      rd_q   <= rd_d;
      good_q <= good_d;
      bad_q  <= bad_d;
      ovf_q  <= ovf_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      cnt_q  <= cnt_d;
      rv_q   <= re;
    end
  end

endmodule
